// File: rtl/run_pkg.sv
// Shared types and default sizing for the host-side run controller.
package run_pkg;

    // Session phases; the FSM walks them strictly in this order.
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StKick,
        StRun,
        StDrain,
        StFin
    } run_state_t;

    localparam int unsigned DEF_AW        = 8;
    localparam int unsigned DEF_LOAD_BASE = 0;
    localparam int unsigned DEF_LOAD_LEN  = 64;
    localparam int unsigned DEF_RES_BASE  = 64;
    localparam int unsigned DEF_RES_LEN   = 32;
    localparam int unsigned DEF_TMO       = 65535;

    // Bits needed to hold the largest of three counts (at least 1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((m >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/run_ctrl.sv
// Run controller: loads host bytes into data memory, kicks the core, waits for done
// (with a watchdog), then drains result bytes back to the host.
module run_ctrl
    import run_pkg::*;
#(
    parameter int unsigned AW        = DEF_AW,
    parameter int unsigned LOAD_BASE = DEF_LOAD_BASE,
    parameter int unsigned LOAD_LEN  = DEF_LOAD_LEN,
    parameter int unsigned RES_BASE  = DEF_RES_BASE,
    parameter int unsigned RES_LEN   = DEF_RES_LEN,
    parameter int unsigned TMO       = DEF_TMO
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          req,
    input  logic          core_done,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,
    output logic          busy,
    output logic          fin,
    output logic          err
);

    localparam int unsigned CW = cnt_width(LOAD_LEN, RES_LEN, TMO);

    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_LEN - 1);
    localparam logic [CW-1:0] RES_LAST  = CW'(RES_LEN - 1);
    localparam logic [CW-1:0] TMO_C     = CW'(TMO);

    run_state_t    r_state;
    run_state_t    w_state_next;
    logic [CW-1:0] r_cnt;   // shared byte index for load and drain
    logic [CW-1:0] r_wdt;   // RUN cycles already elapsed
    logic          r_err;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_last;
    logic w_drain_last;
    logic w_tmo;

    // Handshakes are masked while reset is asserted so no byte moves in a reset cycle.
    assign w_in_fire    = (r_state == StLoad) && (LOAD_LEN != 0) && in_valid && reset;
    assign w_out_fire   = (r_state == StDrain) && (RES_LEN != 0) && out_ready && reset;
    assign w_load_last  = w_in_fire && (r_cnt == LOAD_LAST);
    assign w_drain_last = w_out_fire && (r_cnt == RES_LAST);
    // core_done has priority over an expiring watchdog in the same cycle.
    assign w_tmo        = (r_state == StRun) && !core_done && (r_wdt == TMO_C);

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StLoad;
            StLoad:  if ((LOAD_LEN == 0) || w_load_last) w_state_next = StKick;
            StKick:  w_state_next = StRun;
            StRun: begin
                if (core_done) begin
                    w_state_next = StDrain;
                end else if (w_tmo) begin
                    w_state_next = StFin;
                end
            end
            StDrain: if ((RES_LEN == 0) || w_drain_last) w_state_next = StFin;
            StFin:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // Byte counter: advances on each load/drain handshake, cleared at start and in KICK.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                StIdle:  if (start) r_cnt <= '0;
                StLoad:  if (w_in_fire) r_cnt <= r_cnt + 1'b1;
                StKick:  r_cnt <= '0;
                StDrain: if (w_out_fire) r_cnt <= r_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Watchdog counter: counts RUN cycles; the FSM leaves RUN before it can pass TMO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wdt <= '0;
        end else begin
            unique case (r_state)
                StIdle:  if (start) r_wdt <= '0;
                StKick:  r_wdt <= '0;
                StRun:   r_wdt <= r_wdt + 1'b1;
                default: ;
            endcase
        end
    end

    // Sticky error flag: set on watchdog expiry, cleared by the next accepted start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if ((r_state == StIdle) && start) begin
            r_err <= 1'b0;
        end else if (w_tmo) begin
            r_err <= 1'b1;
        end
    end

    // Outputs decoded from the current state and the live handshakes.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        req       = 1'b0;
        fin       = 1'b0;
        mem_sel   = 1'b1;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        unique case (r_state)
            StLoad: begin
                in_ready  = (LOAD_LEN != 0) && reset;
                mem_addr  = AW'(LOAD_BASE) + AW'(r_cnt);
                mem_wdata = in_data;
                mem_we    = w_in_fire;
            end
            StKick: begin
                req     = 1'b1;
                mem_sel = 1'b0;
            end
            StRun: begin
                mem_sel = 1'b0;
            end
            StDrain: begin
                // Address only moves on a handshake, so out_data is stable while stalled.
                out_valid = (RES_LEN != 0) && reset;
                mem_addr  = AW'(RES_BASE) + AW'(r_cnt);
                out_data  = mem_rdata;
            end
            StFin: begin
                fin = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != StIdle);
    assign err  = r_err;

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: expected memory writes and drain bytes are queued as
// stimulus is driven and popped by a monitor when the DUT performs them.
module tb_run_ctrl;

    localparam int unsigned AW = 8;
    localparam int unsigned LB = 254;
    localparam int unsigned LL = 4;
    localparam int unsigned RB = 64;
    localparam int unsigned RL = 4;
    localparam int unsigned TO = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;
    logic          req;
    logic          core_done;
    logic          mem_sel;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic          busy;
    logic          fin;
    logic          err;

    always #5 clk = ~clk;

    run_ctrl #(
        .AW        (AW),
        .LOAD_BASE (LB),
        .LOAD_LEN  (LL),
        .RES_BASE  (RB),
        .RES_LEN   (RL),
        .TMO       (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .req       (req),
        .core_done (core_done),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .fin       (fin),
        .err       (err)
    );

    // Result memory model: 64..67 hold 0xA0..0xA3, everything else reads 0xEE.
    assign mem_rdata = (mem_addr >= 8'd64 && mem_addr < 8'd68) ?
                       (8'hA0 + (mem_addr - 8'd64)) : 8'hEE;

    int total = 0;
    int bad   = 0;
    int n_wr  = 0;
    logic [15:0] wr_q[$];
    logic [15:0] rd_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every memory write and drain handshake must match the queue head.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            n_wr++;
            if (wr_q.size() == 0) check("wr_unexpected", mem_we, 0);
            else check("wr_addr_data", {mem_addr, mem_wdata}, wr_q.pop_front());
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (rd_q.size() == 0) check("rd_unexpected", out_valid, 0);
            else check("rd_addr_data", {mem_addr, out_data}, rd_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    logic [7:0] ld [4];
    int got_c;
    int n_ov;
    int wr_base;

    initial begin
        ld = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; core_done = 1'b0;
        repeat (2) step();

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_sel", mem_sel, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_req", req, 0);
        check("rst_fin", fin, 0);
        check("rst_err", err, 0);
        step();
        reset = 1'b1;
        step();

        // Session 1: continuous load with address wrap, core done 10 cycles after req,
        // stalled then continuous drain.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_q.push_back({8'(LB + i), ld[i]});
            in_valid = 1'b1; in_data = ld[i];
            @(negedge clk);
            check("ld_in_ready", in_ready, 1);
            check("ld_mem_we", mem_we, 1);
            check("ld_req", req, 0);
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("kick_req", req, 1);
        check("kick_mem_sel", mem_sel, 0);
        step();
        @(negedge clk);
        check("run_req", req, 0);
        check("run_mem_sel", mem_sel, 0);
        check("run_mem_we", mem_we, 0);
        repeat (9) step();
        @(negedge clk);
        check("run_out_valid", out_valid, 0);
        core_done = 1'b1;
        for (int i = 0; i < 4; i++) rd_q.push_back({8'(RB + i), 8'(8'hA0 + i)});
        step();
        core_done = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, 8'hA0);
            check("drain_mem_sel", mem_sel, 1);
            step();
        end
        out_ready = 1'b1;
        repeat (4) step();
        out_ready = 1'b0;
        @(negedge clk);
        check("s1_fin", fin, 1);
        check("s1_fin_out_valid", out_valid, 0);
        check("s1_rd_left", 32'(rd_q.size()), 0);
        step();
        @(negedge clk);
        check("s1_idle_busy", busy, 0);
        check("s1_idle_fin", fin, 0);
        check("s1_err", err, 0);

        // Session 2: toggling in_valid, then watchdog expiry with a stray start in RUN.
        wr_base = n_wr;
        step();
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 8'(8'h50 + i);
            if (i % 2 == 0) wr_q.push_back({8'(LB + i / 2), 8'(8'h50 + i)});
            @(negedge clk);
            if (i % 2 == 1) check("tg_no_write_idle", mem_we, 0);
            check("tg_req", req, (i == 7));
            if (i < 7) step();
        end
        in_valid = 1'b0;
        check("tg_write_count", 32'(n_wr - wr_base), 4);
        got_c = -1;
        n_ov = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            start = (c == 3);
            @(negedge clk);
            if (out_valid) n_ov++;
            if (c == 4) begin
                check("run_start_busy", busy, 1);
                check("run_start_in_ready", in_ready, 0);
                check("run_start_mem_sel", mem_sel, 0);
            end
            if (fin) begin
                got_c = c;
                break;
            end
        end
        start = 1'b0;
        check("tmo_fin_cycle", 32'(got_c), TO + 2);
        check("tmo_err", err, 1);
        check("tmo_no_out_valid", 32'(n_ov), 0);
        step();
        @(negedge clk);
        check("tmo_idle_busy", busy, 0);
        check("tmo_err_sticky", err, 1);

        // Session 3: start clears err, reset during the second load byte aborts.
        step();
        start = 1'b1; step(); start = 1'b0;
        wr_q.push_back({8'(LB), 8'h77});
        in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk);
        check("s3_err_cleared", err, 0);
        check("s3_in_ready", in_ready, 1);
        step();
        in_data = 8'h88;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_mem_we", mem_we, 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_mem_we", mem_we, 0);
        check("abort_mem_sel", mem_sel, 1);
        in_valid = 1'b0;
        step();

        check("wr_q_empty", 32'(wr_q.size()), 0);
        check("rd_q_empty", 32'(rd_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
